// File: rtl/fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_push_arbiter
// Purpose  : Round-robin arbiter sharing the single write port of an 8-bit
//            fifo between NUM_REQ producers using a valid/ack handshake.
//            Each word costs one IDLE (arbitration) cycle plus at least one
//            WRITE (push) cycle, so peak throughput is one word per 2 cycles.
// Ports    : clock      - system clock, rising edge
//            reset      - synchronous, active-low
//            req_valid  - per-requester word valid (held until ack)
//            req_data   - flattened words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//            req_ack    - one-hot, one-cycle pulse when requester's word is written
//            fifo_full  - fifo full flag
//            fifo_busy  - fifo busy flag, push not accepted while high
//            fifo_count - fifo data_count (used only with the watermark option)
//            fifo_push  - fifo push strobe
//            fifo_data  - fifo data_in
//            grant_id   - index of the current or last granted requester
//            arb_active - high while in WRITE
// Option   : `define FIFO_ARB_WATERMARK_EN to restrict grants to requester 0
//            while fifo_count >= WATERMARK.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_push_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 10,
  parameter int WATERMARK   = 960
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  input  logic                          fifo_full,
  input  logic                          fifo_busy,
  input  logic [COUNT_WIDTH-1:0]        fifo_count,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          arb_active
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0]    c_LAST_INIT = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] c_REQ0_MASK = NUM_REQ'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ID_W-1:0]       r_last;
  logic [ID_W-1:0]       r_grant;
  logic [DATA_WIDTH-1:0] r_data;

  logic [NUM_REQ-1:0]    w_elig;
  logic                  w_any;
  logic [ID_W-1:0]       w_winner;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_grant;
  logic                  w_accept;
  logic                  w_above_wm;

  assign w_above_wm = (fifo_count >= COUNT_WIDTH'(WATERMARK));

  // Requesters allowed to compete this cycle.
  always_comb begin
    w_elig = req_valid;
`ifdef FIFO_ARB_WATERMARK_EN
    // Near-full: only requester 0 may win; the pointer is left untouched.
    if (w_above_wm) begin
      w_elig = req_valid & c_REQ0_MASK;
    end
`endif
  end

`ifndef FIFO_ARB_WATERMARK_EN
  logic w_unused_wm;
  assign w_unused_wm = w_above_wm;
`endif

  // Round-robin search: first eligible index at last+1, last+2, ... mod NUM_REQ.
  always_comb begin
    logic [ID_W-1:0] v_idx;
    w_any    = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_idx = ID_W'((int'(r_last) + k) % NUM_REQ);
      if (!w_any && w_elig[v_idx]) begin
        w_any    = 1'b1;
        w_winner = v_idx;
      end
    end
  end

  // Winner's word mux.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_winner) begin
        w_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_grant  = (r_state == S_IDLE) && w_any && !fifo_full && !fifo_busy;
  // Ack is masked while reset is asserted: a write cut short by reset is not
  // considered written and will be retried.
  assign w_accept = (r_state == S_WRITE) && !fifo_full && !fifo_busy && reset;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_next = S_WRITE;
      S_WRITE: if (fifo_full || !fifo_busy) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_last  <= c_LAST_INIT;
      r_grant <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_data  <= w_word;
        r_grant <= w_winner;
      end
      if (w_accept) begin
        r_last <= r_grant;
      end
    end
  end

  always_comb begin
    req_ack = '0;
    if (w_accept) begin
      req_ack[r_grant] = 1'b1;
    end
  end

  // An unexpected full during WRITE drops the push immediately.
  assign fifo_push  = (r_state == S_WRITE) && !fifo_full;
  assign fifo_data  = r_data;
  assign grant_id   = r_grant;
  assign arb_active = (r_state == S_WRITE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_push_arbiter
// Purpose  : Directed self-checking bench for fifo_push_arbiter (NUM_REQ=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_push_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic        fifo_full;
  logic        fifo_busy;
  logic [9:0]  fifo_count;
  logic        fifo_push;
  logic [7:0]  fifo_data;
  logic [1:0]  grant_id;
  logic        arb_active;

  int r_n_cmp;
  int r_n_bad;
  int r_acc;

  fifo_push_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .COUNT_WIDTH(10),
    .WATERMARK  (960)
  ) u_dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .fifo_full (fifo_full),
    .fifo_busy (fifo_busy),
    .fifo_count(fifo_count),
    .fifo_push (fifo_push),
    .fifo_data (fifo_data),
    .grant_id  (grant_id),
    .arb_active(arb_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    r_n_cmp++;
    if (obs !== exp) begin
      r_n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs changed here settle before the
  // following check, which waits a further #1.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    fifo_full  = 1'b0;
    fifo_busy  = 1'b0;
    fifo_count = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    r_n_cmp = 0;
    r_n_bad = 0;

    // 1: reset state, no pushes while idle
    do_reset();
    #1;
    chk("rst_push", fifo_push, 0);
    chk("rst_data", fifo_data, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_act", arb_active, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("idle_push", fifo_push, 0);
    end

    // 2: single requester 2
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'h00F1_0000;
    tick();
    #1;
    chk("r2_push", fifo_push, 1);
    chk("r2_data", fifo_data, 8'hF1);
    chk("r2_ack", req_ack, 4'b0100);
    chk("r2_gid", grant_id, 2);
    chk("r2_act", arb_active, 1);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("r2_after_push", fifo_push, 0);
    chk("r2_after_ack", req_ack, 0);
    chk("r2_keep_gid", grant_id, 2);

    // 3: all requesters valid -> 0,1,2,3,0 every other cycle
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'h1312_1110;
    for (int n = 0; n < 5; n++) begin
      tick();
      #1;
      chk("rr_push", fifo_push, 1);
      chk("rr_data", fifo_data, 8'h10 + (n % 4));
      chk("rr_ack", req_ack, 32'd1 << (n % 4));
      tick();
      #1;
      chk("rr_gap", fifo_push, 0);
    end

    // 4: busy stall for 3 cycles in WRITE
    do_reset();
    req_valid = 4'b0001;
    req_data  = 32'h0000_00FA;
    r_acc     = 0;
    tick();
    fifo_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      #1;
      chk("stall_push", fifo_push, 1);
      chk("stall_data", fifo_data, 8'hFA);
      chk("stall_ack", req_ack, 0);
      if (fifo_push && !fifo_busy) r_acc++;
    end
    tick();
    fifo_busy = 1'b0;
    #1;
    chk("unstall_push", fifo_push, 1);
    chk("unstall_ack", req_ack, 4'b0001);
    if (fifo_push && !fifo_busy) r_acc++;
    tick();
    req_valid = 4'b0000;
    #1;
    chk("stall_idle", fifo_push, 0);
    chk("stall_accepts", r_acc, 1);

    // 5: full blocks arbitration; then 1 before 3
    do_reset();
    fifo_full = 1'b1;
    req_valid = 4'b1010;
    req_data  = 32'hA300_A100;
    for (int c = 0; c < 4; c++) begin
      tick();
      #1;
      chk("full_push", fifo_push, 0);
      chk("full_ack", req_ack, 0);
    end
    fifo_full = 1'b0;
    tick();
    #1;
    chk("full_r1_data", fifo_data, 8'hA1);
    chk("full_r1_ack", req_ack, 4'b0010);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("full_gap", fifo_push, 0);
    tick();
    #1;
    chk("full_r3_data", fifo_data, 8'hA3);
    chk("full_r3_ack", req_ack, 4'b1000);

    // 6: reset during WRITE, then retry of the same word
    do_reset();
    req_valid = 4'b0001;
    req_data  = 32'h0000_0091;
    tick();
    reset = 1'b0;
    #1;
    chk("rw_push_hold", fifo_push, 1);
    chk("rw_no_ack", req_ack, 0);
    tick();
    #1;
    chk("rw_push_drop", fifo_push, 0);
    chk("rw_gid", grant_id, 0);
    chk("rw_act", arb_active, 0);
    reset = 1'b1;
    r_acc = 0;
    tick();
    #1;
    chk("rw_retry_data", fifo_data, 8'h91);
    chk("rw_retry_ack", req_ack, 4'b0001);
    if (fifo_push && !fifo_busy) r_acc++;
    tick();
    req_valid = 4'b0000;
    #1;
    if (fifo_push && !fifo_busy) r_acc++;
    chk("rw_once", r_acc, 1);

    // Watermark: count at 960 with requesters 0 and 1 valid
    do_reset();
    fifo_count = 10'd960;
    req_valid  = 4'b0011;
    req_data   = 32'h0000_B1B0;
    tick();
    #1;
    chk("wm_first_ack", req_ack, 4'b0001);
    tick();
    tick();
    #1;
`ifdef FIFO_ARB_WATERMARK_EN
    chk("wm_second_ack", req_ack, 4'b0001);
    chk("wm_second_data", fifo_data, 8'hB0);
`else
    chk("wm_second_ack", req_ack, 4'b0010);
    chk("wm_second_data", fifo_data, 8'hB1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", r_n_cmp, r_n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
Shares the single write port of the 8-bit `fifo` block between NUM_REQ producer modules using round-robin arbitration. Each producer presents a word with a valid/ack handshake. The arbiter drives the FIFO's push and data_in and honours its full and busy flags. It sits between the producer modules and the `fifo` instance. The FIFO pop side is untouched.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
DATA_WIDTH, 8, word width; matches fifo data_in.
COUNT_WIDTH, 10, width of the fifo data_count input.
WATERMARK, 960, fill level at or above which throttling applies (optional feature only).

Ports:
clock  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-low reset (0 = reset).
req_valid  input  NUM_REQ  per-requester word-valid; held with data until ack.
req_data  input  NUM_REQ*DATA_WIDTH  flattened words; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
req_ack  output  NUM_REQ  one-hot, one-cycle pulse: the word of requester i was written.
fifo_full  input  1  from fifo full.
fifo_busy  input  1  from fifo busy; a push is not accepted while high.
fifo_count  input  COUNT_WIDTH  from fifo data_count.
fifo_push  output  1  to fifo push.
fifo_data  output  DATA_WIDTH  to fifo data_in.
grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.
arb_active  output  1  high while in the WRITE state.

Behaviour:
- Reset (reset=0 at an edge):
  - fifo_push=0, fifo_data=0, req_ack=0, grant_id=0, arb_active=0, state=IDLE.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - Reset overrides every state. If asserted during WRITE, push drops at that edge, no ack is issued and the word is not counted as written.
- States: IDLE, WRITE.
- IDLE:
  - If any req_valid=1, fifo_full=0 and fifo_busy=0: pick the winner as the first valid index searching last+1, last+2, ... modulo NUM_REQ.
  - Register the winner's word into fifo_data, set grant_id=winner, arb_active=1, go to WRITE.
  - Otherwise stay in IDLE with fifo_push=0.
- WRITE:
  - fifo_push=1 and fifo_data stays stable.
  - If fifo_busy=0 in this cycle: the push is accepted. req_ack[grant_id]=1 for exactly this cycle. At the edge, last=grant_id, fifo_push falls, arb_active falls, go to IDLE.
  - If fifo_busy=1: stall in WRITE with push held and no ack. Stalling is unbounded.
  - If fifo_full=1 is seen in WRITE (not reachable with a correct fifo): drop push, no ack, return to IDLE. The requester retries automatically because its req_valid stays high.
- Timing:
  - Latency: req_valid sampled in IDLE → push in the next cycle → ack in the same cycle as the accepted push.
  - Peak throughput is one word per 2 cycles.
- Requester rules:
  - req_data must be stable while req_valid=1 and no ack has been received.
  - req_valid still high in the cycle after the ack means a new word.
  - The arbiter samples req_data only in IDLE. Changes after the grant do not affect the word being written.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ grants.
- Edge cases:
  - Only one valid requester: it wins every arbitration regardless of the pointer.
  - fifo_full held high: no grant, no push and no ack while requests stay pending. Arbitration resumes in the first IDLE cycle after full falls.
  - req_valid dropped by a non-granted requester: no effect.
  - req_valid dropped by the granted requester during WRITE: the write still completes and the ack is still pulsed.

Optional Feature:
FIFO_ARB_WATERMARK_EN
- Defined: in IDLE, when fifo_count >= WATERMARK, only requester 0 may win. Other valid requesters wait and the round-robin pointer is unchanged by the skip. Below WATERMARK, normal round-robin applies.
- Not defined: fifo_count is ignored (the port still exists) and plain round-robin is used.

Test Plan:
1. Reset low for 2 cycles, then high, with req_valid=0 → all outputs 0 and fifo_push never asserted.
2. Only requester 2 valid with data 8'hF1 and fifo idle → fifo_push=1 with fifo_data=8'hF1 one cycle after sampling, req_ack=4'b0100 in the same cycle, grant_id=2.
3. All 4 requesters valid with data 8'h10,8'h11,8'h12,8'h13 and fifo never full → push order 8'h10,8'h11,8'h12,8'h13,8'h10, pushes every other cycle, each ack matching the pushed data's owner.
4. fifo_busy=1 for 3 cycles during WRITE with data 8'hFA → push and data held 3 cycles with no ack; ack on the cycle busy falls; exactly one push accepted.
5. fifo_full=1 with requesters 1 and 3 valid → no push or ack for the whole full period; after full falls, requester 1 is written first, then requester 3.
6. Reset asserted during WRITE with data 8'h91 → push falls at that edge, no ack, grant_id=0; after release the same requester is re-granted and 8'h91 is pushed once. With FIFO_ARB_WATERMARK_EN defined and fifo_count=960, requester 0 and 1 valid → only requester 0 is acked.
